// File: rtl/pkg_en.sv
// rtl/pkg_en.sv - shared token types, widths and FSM state encodings for the external memory access unit
package pkg_en;

    localparam int WIDTH_EXADDR = 16;
    localparam int WIDTH_DATA   = 32;
    localparam int WIDTH_LEN    = 16;
    localparam int DEPTH_SKID   = 2;

    typedef struct packed {
        logic                    v;
        logic                    a;
        logic                    r;
        logic                    c;
        logic [WIDTH_EXADDR-1:0] i;
        logic [WIDTH_DATA-1:0]   d;
    } FTk_t;

    typedef struct packed {
        logic n;
    } BTk_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ld_state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } st_state_t;

endpackage

// File: rtl/ext_mem_skid_buf.sv
// rtl/ext_mem_skid_buf.sv - 2-entry token FIFO absorbing the one-cycle load response latency
module ext_mem_skid_buf
    import pkg_en::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  FTk_t       push_data,
    input  logic       pop,
    output FTk_t       head,
    output logic [1:0] count
);

    FTk_t mem [DEPTH_SKID];
    logic rd_ptr;
    logic wr_ptr;
    logic do_push;
    logic do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int k = 0; k < DEPTH_SKID; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ext_mem_access_unit.sv
// rtl/ext_mem_access_unit.sv - load/store initiator to external memory; EXT_MEM_INDEX_EN adds word offsets in .i
module ext_mem_access_unit
    import pkg_en::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Ld_Start,
    input  logic [WIDTH_EXADDR-1:0] I_Ld_Base,
    input  logic [WIDTH_LEN-1:0]    I_Ld_Len,
    output logic                    O_Ld_Busy,
    output logic                    O_Ld_Done,
    output logic                    O_Ld_Req,
    output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
    input  FTk_t                    I_Ld_FTk,
    output BTk_t                    O_Ld_BTk,
    output FTk_t                    O_FTk,
    input  BTk_t                    I_BTk,
    input  logic                    I_St_Start,
    input  logic [WIDTH_EXADDR-1:0] I_St_Base,
    input  logic [WIDTH_LEN-1:0]    I_St_Len,
    output logic                    O_St_Done,
    input  FTk_t                    I_FTk,
    output BTk_t                    O_BTk,
    output logic                    O_St_Req,
    output logic [WIDTH_EXADDR-1:0] O_St_Addr,
    output FTk_t                    O_St_FTk,
    input  BTk_t                    I_St_BTk
);

    ld_state_t               ld_state, ld_state_nx;
    logic [WIDTH_EXADDR-1:0] ld_base;
    logic [WIDTH_LEN-1:0]    ld_len, ld_remaining, ld_issued, ld_rx;
    logic                    ld_inflight, ld_zero_done, ld_drain_done, ld_req;
    logic [2:0]              ld_credit;
    logic                    skid_push, skid_pop;
    logic [1:0]              skid_count;
    FTk_t                    skid_head, push_tok;

    st_state_t               st_state, st_state_nx;
    logic [WIDTH_EXADDR-1:0] st_base, st_addr;
    logic [WIDTH_LEN-1:0]    st_len, st_count;
    logic                    st_done, st_nack, st_accept, st_commit, st_last;
    FTk_t                    st_stage, st_tok;

    logic unused_bits;
    assign unused_bits = &{1'b0, I_Ld_FTk.a, I_Ld_FTk.r, I_Ld_FTk.c, I_Ld_FTk.i, I_FTk.i};

    ext_mem_skid_buf u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (skid_push),
        .push_data (push_tok),
        .pop       (skid_pop),
        .head      (skid_head),
        .count     (skid_count)
    );

    // The pop frees a slot this cycle, so it is credited back to keep one word per cycle.
    always_comb begin
        ld_state_nx   = ld_state;
        ld_req        = 1'b0;
        ld_drain_done = 1'b0;
        skid_pop      = (skid_count != 2'd0) && !I_BTk.n;
        ld_credit     = {1'b0, skid_count} + {2'b00, ld_inflight};
        case (ld_state)
            IDLE: begin
                if (I_Ld_Start && (I_Ld_Len != '0)) ld_state_nx = RUN;
            end
            RUN: begin
                ld_req = (ld_remaining != '0) && (ld_credit < (3'd2 + {2'b00, skid_pop}));
                if (ld_req && (ld_remaining == WIDTH_LEN'(1))) ld_state_nx = DRAIN;
            end
            DRAIN: begin
                if ((skid_count == 2'd0) && !ld_inflight) begin
                    ld_drain_done = 1'b1;
                    ld_state_nx   = IDLE;
                end
            end
            default: ld_state_nx = IDLE;
        endcase
    end

    always_comb begin
        push_tok   = '0;
        push_tok.v = 1'b1;
        push_tok.a = (ld_rx == '0);
        push_tok.r = (ld_rx == (ld_len - WIDTH_LEN'(1)));
        push_tok.d = I_Ld_FTk.d;
`ifdef EXT_MEM_INDEX_EN
        push_tok.i = WIDTH_EXADDR'(ld_rx);
`else
        push_tok.i = '0;
`endif
    end

    assign skid_push = I_Ld_FTk.v && ld_inflight;
    assign O_Ld_Req  = ld_req;
    assign O_Ld_Addr = ld_req ? (ld_base + WIDTH_EXADDR'(ld_issued)) : '0;
    assign O_Ld_Busy = (ld_state != IDLE);
    assign O_Ld_Done = ld_zero_done || ld_drain_done;
    assign O_Ld_BTk  = '0;
    assign O_FTk     = (skid_count != 2'd0) ? skid_head : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            ld_state     <= IDLE;
            ld_base      <= '0;
            ld_len       <= '0;
            ld_remaining <= '0;
            ld_issued    <= '0;
            ld_rx        <= '0;
            ld_inflight  <= 1'b0;
            ld_zero_done <= 1'b0;
        end else begin
            ld_state     <= ld_state_nx;
            ld_inflight  <= ld_req;
            ld_zero_done <= (ld_state == IDLE) && I_Ld_Start && (I_Ld_Len == '0);
            if ((ld_state == IDLE) && I_Ld_Start) begin
                ld_base      <= I_Ld_Base;
                ld_len       <= I_Ld_Len;
                ld_remaining <= I_Ld_Len;
                ld_issued    <= '0;
                ld_rx        <= '0;
            end else begin
                if (ld_req) begin
                    ld_remaining <= ld_remaining - WIDTH_LEN'(1);
                    ld_issued    <= ld_issued + WIDTH_LEN'(1);
                end
                if (skid_push) ld_rx <= ld_rx + WIDTH_LEN'(1);
            end
        end
    end

    // Once every word is accepted, the stage holds the last one, so its commit ends the transfer.
    always_comb begin
        st_state_nx = st_state;
        st_nack     = 1'b1;
        st_accept   = 1'b0;
        st_last     = 1'b0;
        st_commit   = st_stage.v && !I_St_BTk.n;
        case (st_state)
            ST_IDLE: begin
                if (I_St_Start && (I_St_Len != '0)) st_state_nx = ST_RUN;
            end
            ST_RUN: begin
                st_nack   = (st_stage.v && I_St_BTk.n) || (st_count == st_len);
                st_accept = I_FTk.v && !st_nack;
                st_last   = st_commit && (st_count == st_len);
                if (st_last) st_state_nx = ST_IDLE;
            end
            default: st_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        st_tok   = '0;
        st_tok.v = 1'b1;
        st_tok.a = I_FTk.a;
        st_tok.r = I_FTk.r;
        st_tok.c = I_FTk.c;
        st_tok.d = I_FTk.d;
`ifdef EXT_MEM_INDEX_EN
        st_tok.i = WIDTH_EXADDR'(st_count);
`else
        st_tok.i = '0;
`endif
    end

    assign O_BTk.n   = st_nack;
    assign O_St_Req  = st_stage.v;
    assign O_St_Addr = st_addr;
    assign O_St_FTk  = st_stage;
    assign O_St_Done = st_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            st_state <= ST_IDLE;
            st_base  <= '0;
            st_len   <= '0;
            st_count <= '0;
            st_addr  <= '0;
            st_stage <= '0;
            st_done  <= 1'b0;
        end else begin
            st_state <= st_state_nx;
            st_done  <= ((st_state == ST_IDLE) && I_St_Start && (I_St_Len == '0)) || st_last;
            if ((st_state == ST_IDLE) && I_St_Start) begin
                st_base  <= I_St_Base;
                st_len   <= I_St_Len;
                st_count <= '0;
            end
            if (st_accept) begin
                st_stage <= st_tok;
                st_addr  <= st_base + WIDTH_EXADDR'(st_count);
                st_count <= st_count + WIDTH_LEN'(1);
            end else if (st_commit) begin
                st_stage <= '0;
                st_addr  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ext_mem_access_unit.sv
// tb/tb_ext_mem_access_unit.sv - directed table and sequence bench for ext_mem_access_unit
module tb_ext_mem_access_unit;
    import pkg_en::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_Ld_Start, I_St_Start;
    logic [15:0] I_Ld_Base, I_St_Base, I_Ld_Len, I_St_Len;
    logic        O_Ld_Busy, O_Ld_Done, O_Ld_Req, O_St_Done, O_St_Req;
    logic [15:0] O_Ld_Addr, O_St_Addr;
    FTk_t        ld_resp, O_FTk, I_FTk, O_St_FTk;
    BTk_t        O_Ld_BTk, I_BTk, O_BTk, I_St_BTk;

    logic [31:0] st_mem [0:1023];
    int          st_commits = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;

    ext_mem_access_unit dut (
        .clock(clock), .reset(reset),
        .I_Ld_Start(I_Ld_Start), .I_Ld_Base(I_Ld_Base), .I_Ld_Len(I_Ld_Len),
        .O_Ld_Busy(O_Ld_Busy), .O_Ld_Done(O_Ld_Done), .O_Ld_Req(O_Ld_Req), .O_Ld_Addr(O_Ld_Addr),
        .I_Ld_FTk(ld_resp), .O_Ld_BTk(O_Ld_BTk), .O_FTk(O_FTk), .I_BTk(I_BTk),
        .I_St_Start(I_St_Start), .I_St_Base(I_St_Base), .I_St_Len(I_St_Len), .O_St_Done(O_St_Done),
        .I_FTk(I_FTk), .O_BTk(O_BTk), .O_St_Req(O_St_Req), .O_St_Addr(O_St_Addr),
        .O_St_FTk(O_St_FTk), .I_St_BTk(I_St_BTk)
    );

    function automatic FTk_t mk_tok(input logic [31:0] d);
        FTk_t t;
        t   = '0;
        t.v = 1'b1;
        t.d = d;
        return t;
    endfunction

    // Memory: mem[a] = a + 0x100, one cycle after the request; stores land on un-nacked requests.
    always @(posedge clock) begin
        ld_resp <= O_Ld_Req ? mk_tok(32'(O_Ld_Addr) + 32'h100) : '0;
        if (O_St_Req && !I_St_BTk.n) begin
            st_mem[O_St_Addr[9:0]] <= O_St_FTk.d;
            st_commits             <= st_commits + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        @(negedge clock);
        chk({tag, "_ld_req"},  O_Ld_Req, 0);
        chk({tag, "_ld_addr"}, O_Ld_Addr, 0);
        chk({tag, "_ld_busy"}, O_Ld_Busy, 0);
        chk({tag, "_ld_done"}, O_Ld_Done, 0);
        chk({tag, "_ftk"},     O_FTk, 0);
        chk({tag, "_ld_btk"},  O_Ld_BTk, 0);
        chk({tag, "_st_req"},  O_St_Req, 0);
        chk({tag, "_st_addr"}, O_St_Addr, 0);
        chk({tag, "_st_ftk"},  O_St_FTk, 0);
        chk({tag, "_st_done"}, O_St_Done, 0);
        chk({tag, "_st_nack"}, O_BTk.n, 1);
    endtask

    task automatic run_load(input logic [15:0] base, input logic [15:0] len,
                            input int nack_after, input int nack_cycles);
        int popped = 0, dones = 0, stall = 0;
        I_Ld_Base = base; I_Ld_Len = len; I_Ld_Start = 1'b1;
        tick();
        I_Ld_Start = 1'b0;
        for (int cyc = 0; cyc < 200 && dones == 0; cyc++) begin
            I_BTk.n = (popped >= nack_after) && (stall < nack_cycles);
            if (I_BTk.n) stall++;
            @(negedge clock);
            if (I_BTk.n && stall == nack_cycles && nack_cycles >= 3) begin
                chk("ld_req_stalled", O_Ld_Req, 0);
                chk("ld_head_held", O_FTk.v, 1);
            end
            if (O_FTk.v && !I_BTk.n) begin
                chk("ld_data", O_FTk.d, 32'(16'(base + 16'(popped))) + 32'h100);
                chk("ld_first", O_FTk.a, popped == 0);
                chk("ld_last", O_FTk.r, popped == int'(len) - 1);
                popped++;
            end
            if (O_Ld_Done) dones++;
            tick();
        end
        I_BTk.n = 1'b0;
        chk("ld_count", popped, len);
        chk("ld_done_seen", dones, 1);
        @(negedge clock);
        chk("ld_done_single", O_Ld_Done, 0);
        chk("ld_busy_clear", O_Ld_Busy, 0);
    endtask

    task automatic run_store(input logic [15:0] base, input logic [15:0] len, input logic [31:0] d0,
                             input int stall_idx, input int stall_cycles);
        int idx = 0, dones = 0, stalled = 0, c0;
        c0 = st_commits;
        I_St_Base = base; I_St_Len = len; I_St_Start = 1'b1;
        tick();
        I_St_Start = 1'b0;
        for (int cyc = 0; cyc < 100 && dones == 0; cyc++) begin
            I_FTk = mk_tok(d0 + 32'(idx));
            I_St_BTk.n = O_St_Req && (O_St_Addr == 16'(base + 16'(stall_idx))) && (stalled < stall_cycles);
            if (I_St_BTk.n) stalled++;
            @(negedge clock);
            if (I_St_BTk.n) begin
                chk("st_fabric_nack", O_BTk.n, 1);
                chk("st_addr_held", O_St_Addr, 16'(base + 16'(stall_idx)));
            end
            if (I_FTk.v && !O_BTk.n) idx++;
            if (O_St_Done) dones++;
            tick();
        end
        I_FTk = '0;
        I_St_BTk.n = 1'b0;
        chk("st_accepted", idx, len);
        chk("st_done_seen", dones, 1);
        chk("st_commits", st_commits - c0, len);
        for (int k = 0; k < int'(len); k++) begin
            chk("st_mem", st_mem[10'(base + 16'(k))], d0 + 32'(k));
        end
    endtask

    typedef struct {
        logic        btk_n;
        logic        req;
        logic [15:0] addr;
        logic        v;
        logic [31:0] d;
        logic        a;
        logic        r;
        logic        done;
        logic        busy;
    } ld_vec_t;

    ld_vec_t vec [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec[0] = '{1'b0, 1'b1, 16'h10, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1};
        vec[1] = '{1'b0, 1'b1, 16'h11, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1};
        vec[2] = '{1'b0, 1'b1, 16'h12, 1'b1, 32'h110, 1'b1, 1'b0, 1'b0, 1'b1};
        vec[3] = '{1'b0, 1'b1, 16'h13, 1'b1, 32'h111, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[4] = '{1'b0, 1'b0, 16'h0,  1'b1, 32'h112, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[5] = '{1'b0, 1'b0, 16'h0,  1'b1, 32'h113, 1'b0, 1'b1, 1'b0, 1'b1};
        vec[6] = '{1'b0, 1'b0, 16'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1};
        vec[7] = '{1'b0, 1'b0, 16'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        I_Ld_Start = 1'b0; I_St_Start = 1'b0;
        I_Ld_Base = '0; I_Ld_Len = '0; I_St_Base = '0; I_St_Len = '0;
        I_BTk = '0; I_St_BTk = '0; I_FTk = '0;
        repeat (3) tick();
        chk_quiet("rst");
        tick();
        reset = 1'b0;
        tick();

        // Load base 0x10, length 4, cycle by cycle
        I_Ld_Base = 16'h10; I_Ld_Len = 16'd4; I_Ld_Start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            I_Ld_Start = 1'b0;
            I_BTk.n = vec[k].btk_n;
            @(negedge clock);
            chk($sformatf("t1_req[%0d]", k), O_Ld_Req, vec[k].req);
            if (vec[k].req) chk($sformatf("t1_addr[%0d]", k), O_Ld_Addr, vec[k].addr);
            chk($sformatf("t1_v[%0d]", k), O_FTk.v, vec[k].v);
            if (vec[k].v) begin
                chk($sformatf("t1_d[%0d]", k), O_FTk.d, vec[k].d);
                chk($sformatf("t1_a[%0d]", k), O_FTk.a, vec[k].a);
                chk($sformatf("t1_r[%0d]", k), O_FTk.r, vec[k].r);
                chk($sformatf("t1_c[%0d]", k), O_FTk.c, 0);
            end
            chk($sformatf("t1_done[%0d]", k), O_Ld_Done, vec[k].done);
            chk($sformatf("t1_busy[%0d]", k), O_Ld_Busy, vec[k].busy);
        end
        tick();

        run_load(16'h20, 16'd6, 2, 5);
        run_load(16'hFFFE, 16'd4, 99, 0);

        // Zero-length load and store
        I_Ld_Len = '0; I_Ld_Start = 1'b1; I_St_Len = '0; I_St_Start = 1'b1;
        tick();
        I_Ld_Start = 1'b0; I_St_Start = 1'b0;
        @(negedge clock);
        chk("ld0_done", O_Ld_Done, 1);
        chk("ld0_busy", O_Ld_Busy, 0);
        chk("ld0_req", O_Ld_Req, 0);
        chk("st0_done", O_St_Done, 1);
        chk("st0_req", O_St_Req, 0);
        tick();
        @(negedge clock);
        chk("ld0_done_end", O_Ld_Done, 0);
        chk("ld0_req_end", O_Ld_Req, 0);
        chk("st0_done_end", O_St_Done, 0);
        tick();

        run_store(16'h200, 16'd3, 32'hA, 1, 2);

        fork
            run_load(16'h300, 16'd4, 99, 0);
            run_store(16'h380, 16'd4, 32'h50, 99, 0);
        join
        tick();

        // Reset in the middle of a load, then a clean restart
        I_Ld_Base = 16'h40; I_Ld_Len = 16'd8; I_Ld_Start = 1'b1;
        tick();
        I_Ld_Start = 1'b0;
        begin
            int popped = 0;
            for (int cyc = 0; cyc < 20 && popped < 2; cyc++) begin
                @(negedge clock);
                if (O_FTk.v && !I_BTk.n) popped++;
                tick();
            end
            chk("mid_popped", popped, 2);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_quiet("midrst");
        tick();
        run_load(16'h0, 16'd2, 99, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
